// File: rtl/booth_mac_sequencer_pkg.sv
// Shared types and arithmetic for the booth MAC sequencer: FSM encoding,
// operand/product widths and the sign-extending overflow-aware add.
package booth_mac_sequencer_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ACC  = 2'd2
    } state_t;

    typedef struct packed {
        logic signed [63:0] sum;
        logic               ovf;
    } sum_t;

    // Operands arrive already sign-extended to 64 bits; overflow is judged
    // against a w-bit signed range, so w must stay well below 64.
    function automatic sum_t sext_sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 w,
        input logic               sat
    );
        logic signed [63:0] full;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        sum_t               r;
        full  = a + b;
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        r.ovf = (full > max_v) || (full < min_v);
        r.sum = full;
        if (r.ovf && sat) begin
            r.sum = (full > max_v) ? max_v : min_v;
        end
        return r;
    endfunction

endpackage

// File: rtl/booth_mac_acc_unit.sv
// Combinational accumulate step: acc + sign-extended product, with wrap or
// saturate on signed overflow and an overflow flag.
module booth_mac_acc_unit
    import booth_mac_sequencer_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int SAT   = 0
) (
    input  logic signed [ACC_W-1:0]  acc_i,
    input  logic signed [PROD_W-1:0] prod_i,
    output logic signed [ACC_W-1:0]  sum_o,
    output logic                     ovf_o
);

    sum_t res;
    logic unused_hi;

    always_comb begin
        res       = sext_sat_add(64'(acc_i), 64'(prod_i), ACC_W, SAT != 0);
        sum_o     = res.sum[ACC_W-1:0];
        ovf_o     = res.ovf;
        unused_hi = ^res.sum[63:ACC_W];
    end

endmodule

// File: rtl/booth_mac_sequencer.sv
// Feeds operand pairs to an external booth multiplier, accumulates its
// products into a dot product and emits the result on the last pair.
module booth_mac_sequencer
    import booth_mac_sequencer_pkg::*;
#(
    parameter int ACC_W   = 24,
    parameter int SAT     = 0,
    parameter int TIMEOUT = 63
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     In_Valid,
    output logic                     In_Ready,
    input  logic signed [OP_W-1:0]   In_A,
    input  logic signed [OP_W-1:0]   In_B,
    input  logic                     In_Last,
    output logic                     Mul_Start,
    output logic signed [OP_W-1:0]   Mul_A,
    output logic signed [OP_W-1:0]   Mul_B,
    input  logic                     Mul_Done,
    input  logic signed [PROD_W-1:0] Mul_Product,
    output logic                     Acc_Valid,
    output logic signed [ACC_W-1:0]  Acc_Data,
    output logic                     Acc_Ovf,
    output logic                     Err
);

    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t                    state_q, state_d;
    logic                      mul_start_q, mul_start_d;
    logic signed [OP_W-1:0]    mul_a_q, mul_a_d;
    logic signed [OP_W-1:0]    mul_b_q, mul_b_d;
    logic                      last_q, last_d;
    logic signed [PROD_W-1:0]  prod_q, prod_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      sticky_q, sticky_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      acc_valid_q, acc_valid_d;
    logic signed [ACC_W-1:0]   acc_data_q, acc_data_d;
    logic                      acc_ovf_q, acc_ovf_d;
    logic                      err_q, err_d;

    logic signed [ACC_W-1:0]   sum;
    logic                      ovf;

    booth_mac_acc_unit #(
        .ACC_W (ACC_W),
        .SAT   (SAT)
    ) u_acc (
        .acc_i  (acc_q),
        .prod_i (prod_q),
        .sum_o  (sum),
        .ovf_o  (ovf)
    );

    always_comb begin
        state_d     = state_q;
        mul_start_d = mul_start_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        last_d      = last_q;
        prod_d      = prod_q;
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        cnt_d       = cnt_q;
        acc_valid_d = 1'b0;
        acc_data_d  = acc_data_q;
        acc_ovf_d   = acc_ovf_q;
        err_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (In_Valid) begin
                    mul_a_d     = In_A;
                    mul_b_d     = In_B;
                    last_d      = In_Last;
                    mul_start_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                if (Mul_Done) begin
                    prod_d      = Mul_Product;
                    mul_start_d = 1'b0;
                    state_d     = ST_ACC;
                end else if (cnt_q == CNT_MAX) begin
                    // Abort drops the whole group; Acc_Data keeps the last result.
                    mul_start_d = 1'b0;
                    err_d       = 1'b1;
                    acc_d       = '0;
                    sticky_d    = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ACC: begin
                if (last_q) begin
                    acc_data_d  = sum;
                    acc_ovf_d   = sticky_q | ovf;
                    acc_valid_d = 1'b1;
                    acc_d       = '0;
                    sticky_d    = 1'b0;
                end else begin
                    acc_d    = sum;
                    sticky_d = sticky_q | ovf;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            last_q      <= 1'b0;
            prod_q      <= '0;
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
            acc_valid_q <= 1'b0;
            acc_data_q  <= '0;
            acc_ovf_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mul_start_q <= mul_start_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            last_q      <= last_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
            acc_valid_q <= acc_valid_d;
            acc_data_q  <= acc_data_d;
            acc_ovf_q   <= acc_ovf_d;
            err_q       <= err_d;
        end
    end

    assign In_Ready  = (state_q == ST_IDLE);
    assign Mul_Start = mul_start_q;
    assign Mul_A     = mul_a_q;
    assign Mul_B     = mul_b_q;
    assign Acc_Valid = acc_valid_q;
    assign Acc_Data  = acc_data_q;
    assign Acc_Ovf   = acc_ovf_q;
    assign Err       = err_q;

endmodule

// File: tb/tb_booth_mac_sequencer.sv
// Bench for booth_mac_sequencer: three instances (24-bit wrap, 16-bit wrap,
// 16-bit saturate) driven in lockstep, each with its own level-start multiplier.
module tb_booth_mac_sequencer;

    localparam int LAT = 4;

    logic CLK, RST, in_valid, in_last, mul_en;
    logic signed [7:0] in_a, in_b;
    logic in_ready [3];
    logic mstart [3];
    logic mdone [3];
    logic acc_valid [3];
    logic acc_ovf [3];
    logic err [3];
    logic signed [7:0]  ma [3];
    logic signed [7:0]  mb [3];
    logic signed [15:0] mp [3];
    logic [23:0] d24;
    logic [15:0] d16w, d16s;

    int tests = 0;
    int fails = 0;
    int vcnt [3];
    int viol;
    bit dprev [3];
    bit dprev2 [3];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    booth_mac_sequencer #(.ACC_W(24), .SAT(0), .TIMEOUT(63)) dut0 (
        .CLK(CLK), .RST(RST), .In_Valid(in_valid), .In_Ready(in_ready[0]),
        .In_A(in_a), .In_B(in_b), .In_Last(in_last), .Mul_Start(mstart[0]),
        .Mul_A(ma[0]), .Mul_B(mb[0]), .Mul_Done(mdone[0]), .Mul_Product(mp[0]),
        .Acc_Valid(acc_valid[0]), .Acc_Data(d24), .Acc_Ovf(acc_ovf[0]), .Err(err[0]));

    booth_mac_sequencer #(.ACC_W(16), .SAT(0), .TIMEOUT(63)) dut1 (
        .CLK(CLK), .RST(RST), .In_Valid(in_valid), .In_Ready(in_ready[1]),
        .In_A(in_a), .In_B(in_b), .In_Last(in_last), .Mul_Start(mstart[1]),
        .Mul_A(ma[1]), .Mul_B(mb[1]), .Mul_Done(mdone[1]), .Mul_Product(mp[1]),
        .Acc_Valid(acc_valid[1]), .Acc_Data(d16w), .Acc_Ovf(acc_ovf[1]), .Err(err[1]));

    booth_mac_sequencer #(.ACC_W(16), .SAT(1), .TIMEOUT(63)) dut2 (
        .CLK(CLK), .RST(RST), .In_Valid(in_valid), .In_Ready(in_ready[2]),
        .In_A(in_a), .In_B(in_b), .In_Last(in_last), .Mul_Start(mstart[2]),
        .Mul_A(ma[2]), .Mul_B(mb[2]), .Mul_Done(mdone[2]), .Mul_Product(mp[2]),
        .Acc_Valid(acc_valid[2]), .Acc_Data(d16s), .Acc_Ovf(acc_ovf[2]), .Err(err[2]));

    // Multiplier: loads on a start level, pulses done after LAT cycles, and
    // re-arms only after start has dropped (would self-restart otherwise).
    for (genvar g = 0; g < 3; g++) begin : gm
        logic [1:0] st;
        logic [3:0] cnt;
        logic signed [7:0] ra, rb;
        always @(posedge CLK or posedge RST) begin
            if (RST) begin
                st <= 2'd0; cnt <= 4'd0; ra <= 8'sd0; rb <= 8'sd0;
                mdone[g] <= 1'b0; mp[g] <= 16'sd0;
            end else begin
                mdone[g] <= 1'b0;
                case (st)
                    2'd0: if (mstart[g]) begin
                        ra <= ma[g]; rb <= mb[g]; cnt <= 4'(LAT - 1); st <= 2'd1;
                    end
                    2'd1: begin
                        if (!mstart[g]) st <= 2'd0;
                        else if (cnt != 4'd0) cnt <= cnt - 4'd1;
                        else if (mul_en) begin
                            mdone[g] <= 1'b1; mp[g] <= ra * rb; st <= 2'd2;
                        end
                    end
                    default: if (!mstart[g]) st <= 2'd0;
                endcase
            end
        end
    end

    always @(negedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            if (acc_valid[i]) vcnt[i] <= vcnt[i] + 1;
            if (((dprev[i] || dprev2[i]) && mstart[i]) || (acc_valid[i] && err[i]))
                viol <= viol + 1;
            dprev2[i] <= dprev[i];
            dprev[i]  <= mdone[i];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called with the DUTs idle, away from the rising edge.
    task automatic send(input logic signed [7:0] a, input logic signed [7:0] b,
                        input logic last, input string tag);
        int n;
        in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        chk({tag, "_mul_a"}, {24'd0, ma[0]}, {24'd0, a});
        chk({tag, "_mul_b"}, {24'd0, mb[0]}, {24'd0, b});
        n = 0;
        while (!in_ready[0] && n < 40) begin
            @(posedge CLK); #1;
            n++;
        end
        chk({tag, "_back_to_idle"}, {31'd0, in_ready[0]}, 32'd1);
        @(negedge CLK); #1;
    endtask

    typedef struct {
        logic signed [7:0] a;
        logic signed [7:0] b;
        logic              last;
        logic [23:0]       e24;
        logic              o24;
        logic [15:0]       e16w;
        logic              o16w;
        logic [15:0]       e16s;
        logic              o16s;
    } vec_t;

    vec_t vt [8];
    int   v0 [3];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{8'sh03, 8'sh04, 1'b0, 24'h0,      1'b0, 16'h0,    1'b0, 16'h0,    1'b0};
        vt[1] = '{8'shFE, 8'sh05, 1'b0, 24'h0,      1'b0, 16'h0,    1'b0, 16'h0,    1'b0};
        vt[2] = '{8'sh7F, 8'sh7F, 1'b1, 24'h003F03, 1'b0, 16'h3F03, 1'b0, 16'h3F03, 1'b0};
        vt[3] = '{8'sh80, 8'sh80, 1'b0, 24'h0,      1'b0, 16'h0,    1'b0, 16'h0,    1'b0};
        vt[4] = '{8'sh80, 8'sh80, 1'b0, 24'h0,      1'b0, 16'h0,    1'b0, 16'h0,    1'b0};
        vt[5] = '{8'sh80, 8'sh80, 1'b1, 24'h00C000, 1'b0, 16'hC000, 1'b1, 16'h7FFF, 1'b1};
        vt[6] = '{8'shFF, 8'sh01, 1'b1, 24'hFFFFFF, 1'b0, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0};
        vt[7] = '{8'sh05, 8'sh05, 1'b1, 24'h000019, 1'b0, 16'h0019, 1'b0, 16'h0019, 1'b0};

        RST = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_a = 8'sd0; in_b = 8'sd0;
        mul_en = 1'b1; viol = 0;
        for (int i = 0; i < 3; i++) begin
            vcnt[i] = 0; dprev[i] = 1'b0; dprev2[i] = 1'b0;
        end
        repeat (2) @(negedge CLK);
        chk("rst_in_ready",  {31'd0, in_ready[0]},  32'd1);
        chk("rst_mul_start", {31'd0, mstart[0]},    32'd0);
        chk("rst_mul_a",     {24'd0, ma[0]},        32'd0);
        chk("rst_acc_valid", {31'd0, acc_valid[0]}, 32'd0);
        chk("rst_acc_data",  {8'd0, d24},           32'd0);
        chk("rst_acc_ovf",   {31'd0, acc_ovf[0]},   32'd0);
        chk("rst_err",       {31'd0, err[0]},       32'd0);
        RST = 1'b0;
        #1;

        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 3; k++) v0[k] = vcnt[k];
            send(vt[i].a, vt[i].b, vt[i].last, $sformatf("v%0d", i));
            for (int k = 0; k < 3; k++)
                chk($sformatf("v%0d_valid_pulses_dut%0d", i, k),
                    32'(vcnt[k] - v0[k]), vt[i].last ? 32'd1 : 32'd0);
            if (vt[i].last) begin
                chk($sformatf("v%0d_data24", i),  {8'd0, d24},        {8'd0, vt[i].e24});
                chk($sformatf("v%0d_ovf24", i),   {31'd0, acc_ovf[0]}, {31'd0, vt[i].o24});
                chk($sformatf("v%0d_data16w", i), {16'd0, d16w},      {16'd0, vt[i].e16w});
                chk($sformatf("v%0d_ovf16w", i),  {31'd0, acc_ovf[1]}, {31'd0, vt[i].o16w});
                chk($sformatf("v%0d_data16s", i), {16'd0, d16s},      {16'd0, vt[i].e16s});
                chk($sformatf("v%0d_ovf16s", i),  {31'd0, acc_ovf[2]}, {31'd0, vt[i].o16s});
            end
        end

        // Timeout: a partial group is built, then the multiplier never answers.
        send(8'sd10, 8'sd10, 1'b0, "tmo_pre");
        begin
            int n;
            for (int k = 0; k < 3; k++) v0[k] = vcnt[k];
            mul_en = 1'b0;
            in_a = 8'sd1; in_b = 8'sd1; in_last = 1'b0; in_valid = 1'b1;
            @(posedge CLK); #1;
            in_valid = 1'b0;
            n = 0;
            while (!err[0] && n < 100) begin
                @(posedge CLK); #1;
                n++;
            end
            chk("tmo_err_cycles", 32'(n), 32'd64);
            chk("tmo_err_dut1",   {31'd0, err[1]},    32'd1);
            chk("tmo_err_dut2",   {31'd0, err[2]},    32'd1);
            chk("tmo_mul_start",  {31'd0, mstart[0]}, 32'd0);
            chk("tmo_in_ready",   {31'd0, in_ready[0]}, 32'd1);
            chk("tmo_acc_data",   {8'd0, d24},        32'd25);
            @(posedge CLK); #1;
            chk("tmo_err_one_cycle", {31'd0, err[0]},    32'd0);
            chk("tmo_mul_start_next", {31'd0, mstart[0]}, 32'd0);
            chk("tmo_no_valid", 32'(vcnt[0] - v0[0]), 32'd0);
            mul_en = 1'b1;
            @(negedge CLK); #1;
        end
        send(8'sd2, 8'sd2, 1'b1, "post_tmo");
        chk("post_tmo_data24",  {8'd0, d24},   32'd4);
        chk("post_tmo_data16w", {16'd0, d16w}, 32'd4);
        chk("post_tmo_data16s", {16'd0, d16s}, 32'd4);
        chk("post_tmo_ovf24",   {31'd0, acc_ovf[0]}, 32'd0);

        // Asynchronous reset while the multiplier is busy mid-group.
        send(8'sd7, 8'sd7, 1'b0, "rst_pre");
        in_a = 8'sd9; in_b = 8'sd9; in_last = 1'b0; in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        @(posedge CLK); #3;
        chk("mid_run_start_high", {31'd0, mstart[0]}, 32'd1);
        RST = 1'b1;
        #1;
        chk("arst_in_ready",  {31'd0, in_ready[0]},  32'd1);
        chk("arst_mul_start", {31'd0, mstart[0]},    32'd0);
        chk("arst_mul_a",     {24'd0, ma[0]},        32'd0);
        chk("arst_acc_valid", {31'd0, acc_valid[0]}, 32'd0);
        chk("arst_acc_data",  {8'd0, d24},           32'd0);
        chk("arst_acc_data16", {16'd0, d16s},        32'd0);
        chk("arst_acc_ovf",   {31'd0, acc_ovf[0]},   32'd0);
        chk("arst_err",       {31'd0, err[0]},       32'd0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        send(8'sd2, 8'sd3, 1'b1, "post_rst");
        chk("post_rst_data24",  {8'd0, d24},   32'd6);
        chk("post_rst_data16w", {16'd0, d16w}, 32'd6);
        chk("post_rst_ovf24",   {31'd0, acc_ovf[0]}, 32'd0);

        repeat (3) @(negedge CLK);
        chk("start_protocol_and_exclusive_strobes", 32'(viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/booth_mac_sequencer.md
Name: booth_mac_sequencer

Overview:
- Drives one external booth multiplier instance and sits on both sides of it: feeds it signed 8-bit operand pairs (upstream) and consumes its 16-bit products (downstream).
- Accepts a stream of operand pairs over a valid/ready handshake and runs one multiplication per pair.
- Sign-extends and accumulates each product into a signed accumulator, and emits a dot-product result when the pair flagged last has been accumulated.
- Supplies the multiplier's start/done protocol so the multiplier never self-restarts.

Parameters:
- ACC_W, 24, accumulator/result width in bits; legal range is 16 or more.
- SAT, 0, overflow policy: 0 wraps two's-complement, 1 saturates to the signed min/max.
- TIMEOUT, 63, maximum number of cycles spent in RUN without Mul_Done before the sequencer aborts.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- In_Valid  in  1  an operand pair is offered.
- In_Ready  out  1  the sequencer can accept a pair.
- In_A  in  8  signed multiplicand.
- In_B  in  8  signed multiplier.
- In_Last  in  1  this pair ends the current dot product.
- Mul_Start  out  1  multiplier start level (held high for the whole operation).
- Mul_A  out  8  multiplicand to the multiplier.
- Mul_B  out  8  multiplier operand to the multiplier.
- Mul_Done  in  1  one-cycle completion pulse from the multiplier.
- Mul_Product  in  16  signed product, valid while Mul_Done is high.
- Acc_Valid  out  1  one-cycle result strobe.
- Acc_Data  out  ACC_W  signed dot-product result; held until the next result.
- Acc_Ovf  out  1  signed overflow occurred in the group now on Acc_Data.
- Err  out  1  one-cycle pulse on multiplier timeout.

Behaviour:
- Reset values (RST high, asynchronous): state IDLE; In_Ready=1; Mul_Start=0; Mul_A=0; Mul_B=0; Acc_Valid=0; Acc_Data=0; Acc_Ovf=0; Err=0; accumulator=0; timeout counter=0; sticky overflow=0.
- Reset mid-operation forces Mul_Start low immediately and abandons any in-flight product and partial sum.
- FSM states: IDLE, RUN, ACC.
- IDLE:
  - In_Ready=1.
  - When In_Valid is high, register In_A→Mul_A, In_B→Mul_B and In_Last→last_q, set Mul_Start<=1, clear the timeout counter, go to RUN.
- RUN:
  - In_Ready=0; Mul_Start stays 1; Mul_A and Mul_B are held stable.
  - When Mul_Done is high: capture Mul_Product into prod_q, set Mul_Start<=0, go to ACC.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT: Mul_Start<=0, pulse Err for 1 cycle, clear the accumulator and sticky overflow, go to IDLE. The aborted group is dropped; the next accepted pair starts a new group. Acc_Data is unchanged.
- ACC:
  - In_Ready=0; Mul_Start=0.
  - sum = acc + sign_extend(prod_q, ACC_W). Signed overflow is detected from the operand signs versus the result sign.
  - On overflow: SAT=1 clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1); SAT=0 keeps the wrapped sum. Either way sticky overflow is set.
  - If last_q: Acc_Data<=result, Acc_Ovf<=(sticky | this overflow), Acc_Valid pulses 1 cycle, accumulator and sticky are cleared.
  - Otherwise the accumulator is updated with the result.
  - Always go to IDLE.
- Start protocol: Mul_Start is low for at least the ACC and IDLE cycles between operations. This guarantees the multiplier returns to idle and does not reload operands.
- Throughput: one pair every (multiplier latency + 3) cycles.
- Acc_Valid and Err are never high in the same cycle.
- A single pair with In_Last=1 is a complete group.

Decomposition:
- Shared package holds:
  - FSM state encoding constants (IDLE, RUN, ACC);
  - operand width 8 and product width 16;
  - a sign-extend/saturating-add function, parameterised on ACC_W.
- One sub-module is natural: booth_mac_acc_unit, combinational. It takes acc, prod and SAT and produces the next sum and the overflow flag, and is unit-testable on its own.
- The multiplier is instantiated at the parent level, not inside this block.

Test Plan:
- Three pairs (3,4), (-2,5), (127,127 last), with the real multiplier attached → one Acc_Valid; Acc_Data=16131 (0x003F03); Acc_Ovf=0; Mul_Start drops after each Mul_Done and never re-asserts before ACC has completed.
- ACC_W=16, SAT=0: three pairs (-128,-128), the third with last → Acc_Data=0xC000 (-16384); Acc_Ovf=1.
- Same stimulus with SAT=1 → Acc_Data=0x7FFF; Acc_Ovf=1.
- Single pair (-1,1 last) followed immediately by (5,5 last) → Acc_Data=-1 (all ones), then 25. Acc_Ovf=0 for both; the accumulator is cleared between groups.
- Mul_Done tied low, one pair offered → Err pulses exactly TIMEOUT+1 cycles after entry to RUN (63 by default, plus 1); Mul_Start=0 the next cycle; In_Ready=1; Acc_Data unchanged.
- RST asserted while in RUN mid-group, then (2,3 last) offered → all outputs at reset values asynchronously; the following result is Acc_Data=6.
